coin_acceptor_tx: RTL
=====================

COIN_ACCEPTOR_TX -- requirements
Module: coin_acceptor_tx

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a sensor level must differ from its debounced value before the debounced value flips (range 1..255).
REQ-002 SHALL have parameter MIN_GAP, default 2: idle cycles forced after each emitted coin pulse (range 0..15).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: coin queue entries (power of 2, 2..16).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port sens_5, input, 1: raw 5-cent coin sensor level, possibly bouncy.
REQ-007 SHALL have port sens_10, input, 1: raw 10-cent coin sensor level, possibly bouncy.
REQ-008 SHALL have port hold, input, 1: downstream busy (dispensing); while high, no new pulse starts.
REQ-009 SHALL have port coin_5, output, 1: one-cycle 5-cent pulse to the vending FSM.
REQ-010 SHALL have port coin_10, output, 1: one-cycle 10-cent pulse to the vending FSM.
REQ-011 SHALL have port reject, output, 1: one-cycle pulse; coin dropped and returned to customer.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: queued coin count.

Function
REQ-013 Each sensor SHALL pass through its own debouncer; a debounced 0->1 transition is one coin event; 1->0 is ignored.
REQ-014 A coin event SHALL write its coin_t code into the FIFO on the next clock edge if not full.
REQ-015 A coin event arriving when FIFO full and no pop occurs that cycle SHALL be dropped and pulse reject; with a simultaneous pop, the write SHALL succeed and count stays FIFO_DEPTH.
REQ-016 5- and 10-cent events in the same cycle SHALL both be dropped (jam) with one reject pulse.
REQ-017 The emitter FSM SHALL have states IDLE, PULSE, GAP.
REQ-018 IDLE->PULSE when FIFO non-empty and hold low: pop head and register coin_5 or coin_10 high for exactly one cycle.
REQ-019 PULSE->GAP when MIN_GAP>0, else PULSE->IDLE; GAP counts MIN_GAP cycles regardless of hold, then ->IDLE.
REQ-020 coin_5 and coin_10 SHALL never be high together; pulses SHALL be separated by at least MIN_GAP low cycles; FIFO order SHALL be preserved.
REQ-021 With SYNC disabled, a clean sensor rise at edge 0 SHALL produce the coin pulse in the cycle after edge DEBOUNCE_CYCLES+2 (empty FIFO, IDLE, hold low).
REQ-022 hold rising during PULSE SHALL NOT truncate the pulse.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL equal writes minus pops.

Reset
REQ-024 When rst is high at a clock edge: FSM->IDLE, FIFO empty, fifo_count=0, coin_5=coin_10=reject=0, debounced levels and debounce counters cleared, gap counter 0.
REQ-025 rst mid-operation SHALL discard queued coins and abort any GAP; a sensor held high through reset SHALL produce a new event after DEBOUNCE_CYCLES.

Configuration
REQ-026 Macro COIN_ACCEPTOR_SYNC_EN defined: each sensor SHALL pass through a two-flop synchronizer before its debouncer, adding 2 cycles latency; synchronizer flops reset to 0.
REQ-027 Macro COIN_ACCEPTOR_SYNC_EN undefined: sensors SHALL feed debouncers directly; all other behaviour identical.

Structure
REQ-028 Package vending_pkg SHALL hold coin_t (COIN_5, COIN_10) and tx_state_t (IDLE, PULSE, GAP) typedefs.
REQ-029 Sub-module coin_debounce (DEBOUNCE_CYCLES parameter; clk, rst, in, level, rise) SHALL be instantiated once per sensor; FIFO and FSM stay in the top module.

Verification
REQ-030 Bench SHALL cover: sens_5 high 10 cycles with 3 bounce toggles first, DEBOUNCE_CYCLES=4 -> exactly one coin_5 pulse, no reject.
REQ-031 Bench SHALL cover: 6 clean coins (5,10,5,10,10,5), hold low, FIFO_DEPTH=4, MIN_GAP=2 -> all 6 emitted in order, >=2 idle cycles between pulses, reject never high.
REQ-032 Bench SHALL cover: hold high, 5 coin events -> 4 queued, fifo_count=4, 5th rejects; hold low -> 4 pulses in order.
REQ-033 Bench SHALL cover: sens_5 and sens_10 rise same cycle -> one reject, no coin pulse, fifo_count=0.
REQ-034 Bench SHALL cover: 3 coins queued, rst high one cycle during GAP -> no further pulses, fifo_count=0, outputs 0.
REQ-035 Bench SHALL cover: build with and without COIN_ACCEPTOR_SYNC_EN -> clean-rise-to-pulse latency differs by exactly 2 cycles.

Source files
------------

// File: rtl/coin_acceptor_tx_pkg.sv
// ============================================================================
// Module      : vending_pkg
// Description : Shared types for the coin acceptor transmitter: coin codes
//               stored in the coin queue and the emitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vending_pkg;

  // Coin code held in each queue entry
  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_t;

  // Emitter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Counter widths sized for the legal parameter ranges
  localparam int DEB_CNT_W = 8;  // DEBOUNCE_CYCLES up to 255
  localparam int GAP_CNT_W = 4;  // MIN_GAP up to 15

endpackage

`default_nettype wire

// File: rtl/coin_debounce.sv
// ============================================================================
// Module      : coin_debounce
// Description : Single-sensor debouncer. The debounced level flips after the
//               raw input has differed from it for DEBOUNCE_CYCLES
//               consecutive cycles; rise pulses for one cycle on each
//               debounced 0->1 transition.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_debounce
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_CNT_W-1:0] cnt;
  logic                 level_d;

  // Count consecutive disagreeing samples, flip the level on the last one,
  // and register a one-cycle rise pulse from the delayed level copy
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
    end else begin
      if (in != level) begin
        if (cnt == CNT_LAST) begin
          level <= in;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/coin_acceptor_tx.sv
// ============================================================================
// Module      : coin_acceptor_tx
// Description : Debounces the 5- and 10-cent coin sensors, queues coin events
//               in a small FIFO and emits one-cycle coin pulses to the
//               vending FSM with a minimum idle gap between pulses. Jammed
//               (simultaneous) or overflowing coins raise a reject pulse.
//               Optional macro COIN_ACCEPTOR_SYNC_EN inserts a two-flop
//               synchronizer ahead of each debouncer (+2 cycles latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coin_acceptor_tx
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GAP         = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sens_5,
  input  logic                          sens_10,
  input  logic                          hold,
  output logic                          coin_5,
  output logic                          coin_10,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                   AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = (MIN_GAP > 0) ? GAP_CNT_W'(MIN_GAP - 1) : '0;

  // --------------------------------------------------------------------------
  // Sensor conditioning
  // --------------------------------------------------------------------------
  logic in_5, in_10;

`ifdef COIN_ACCEPTOR_SYNC_EN
  logic [1:0] sync_5, sync_10;

  // Two-flop synchronizers for the asynchronous sensor levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_5  <= 2'b00;
      sync_10 <= 2'b00;
    end else begin
      sync_5  <= {sync_5[0], sens_5};
      sync_10 <= {sync_10[0], sens_10};
    end
  end

  assign in_5  = sync_5[1];
  assign in_10 = sync_10[1];
`else
  assign in_5  = sens_5;
  assign in_10 = sens_10;
`endif

  logic level_5, level_10;
  logic rise_5, rise_10;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_5 (
    .clk   (clk),
    .rst   (rst),
    .in    (in_5),
    .level (level_5),
    .rise  (rise_5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_10 (
    .clk   (clk),
    .rst   (rst),
    .in    (in_10),
    .level (level_10),
    .rise  (rise_10)
  );

  // Debounced levels are not needed here; only the rise events matter
  logic unused_levels;
  assign unused_levels = level_5 ^ level_10;

  // --------------------------------------------------------------------------
  // Coin queue
  // --------------------------------------------------------------------------
  coin_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, ev_one, jam, push, pop;
  coin_t         ev_code, head;

  assign full    = (count == DEPTH_V);
  assign ev_one  = rise_5 ^ rise_10;
  assign jam     = rise_5 & rise_10;
  assign ev_code = rise_10 ? COIN_10 : COIN_5;
  // A full queue still accepts a coin when the head leaves in the same cycle
  assign push    = ev_one & (~full | pop);
  assign head    = mem[rd_ptr];

  // Queue storage; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ev_code;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_count = count;

  // --------------------------------------------------------------------------
  // Emitter FSM
  // --------------------------------------------------------------------------
  tx_state_t            state, state_nxt;
  logic [GAP_CNT_W-1:0] gap_cnt, gap_cnt_nxt;

  // State, gap counter and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      coin_5  <= 1'b0;
      coin_10 <= 1'b0;
      reject  <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      coin_5  <= pop & (head == COIN_5);
      coin_10 <= pop & (head == COIN_10);
      reject  <= jam | (ev_one & full & ~pop);
    end
  end

  // Next-state logic; hold only gates the start of a pulse, never the gap
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !hold) begin
          pop       = 1'b1;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        gap_cnt_nxt = '0;
        state_nxt   = (MIN_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
